pipe_ctrl_chain: RTL and testbench

Parametrised in-order pipeline skeleton for the next-generation CPU core. It generalises the fixed five-stage valid/allow_in wiring into STAGES identical stage slots. Each slot carries a payload plus register-file write tags, and the block adds flush-from-stage, a RAW-hazard scoreboard query and a stall counter. It sits between fetch (upstream producer) and writeback (downstream sink), replacing hand-wired per-stage valid registers and exe/mem hazard signals.

---
 rtl/pipe_ctrl_chain.sv | 143 ++++++++++++++
 tb/tb_pipe_ctrl_chain.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_chain.sv
// Parametrised in-order pipeline control chain: valid/allow handshake,
// flush-from-stage, RAW scoreboard query and input stall counter.
module pipe_ctrl_chain #(
    parameter int STAGES    = 5,
    parameter int DATA_W    = 64,
    parameter int RF_ADDR_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_allow,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_rf_we,
    input  logic [RF_ADDR_W-1:0]          in_rf_waddr,
    input  logic [STAGES-1:0]             stage_ready_go,
    input  logic [STAGES-1:0]             flush_req,
    output logic                          out_valid,
    input  logic                          out_allow,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_rf_we,
    output logic [RF_ADDR_W-1:0]          out_rf_waddr,
    output logic [STAGES-1:0]             stage_valid,
    output logic [STAGES*DATA_W-1:0]      stage_data,
    input  logic [RF_ADDR_W-1:0]          query_raddr1,
    input  logic [RF_ADDR_W-1:0]          query_raddr2,
    output logic [STAGES-1:0]             hit_vec1,
    output logic [STAGES-1:0]             hit_vec2,
    output logic [$clog2(STAGES+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES-1:0]    valid_q;
    logic [STAGES-1:0]    we_q;
    logic [DATA_W-1:0]    data_q  [STAGES];
    logic [RF_ADDR_W-1:0] waddr_q [STAGES];
    logic [CNT_W-1:0]     cnt_q;

    logic [STAGES-1:0]    go;
    logic [STAGES-1:0]    allow;
    logic [STAGES-1:0]    kill;
    logic [STAGES-1:0]    supp;
    logic [STAGES-1:0]    load;
    logic [STAGES-1:0]    wr;
    logic [STAGES-1:0]    src_v;
    logic [STAGES-1:0]    src_we;
    logic [DATA_W-1:0]    src_d  [STAGES];
    logic [RF_ADDR_W-1:0] src_wa [STAGES];
    logic                 allow_acc;
    logic                 flush_acc;
    logic [OCC_W-1:0]     occ;

    assign go = valid_q & stage_ready_go;

    always_comb begin
        allow     = '0;
        allow_acc = ~valid_q[STAGES-1] | (go[STAGES-1] & out_allow);
        allow[STAGES-1] = allow_acc;
        for (int i = STAGES-2; i >= 0; i--) begin
            allow_acc = ~valid_q[i] | (go[i] & allow_acc);
            allow[i]  = allow_acc;
        end
    end

    // kill: some older slot requested a flush; supp: no load into this slot
    always_comb begin
        kill      = '0;
        supp      = '0;
        flush_acc = 1'b0;
        for (int i = STAGES-1; i >= 0; i--) begin
            kill[i]   = flush_acc;
            flush_acc = flush_acc | flush_req[i];
            supp[i]   = flush_acc;
        end
    end

    assign src_v  = {go[STAGES-2:0], in_valid};
    assign src_we = {we_q[STAGES-2:0], in_rf_we};
    assign load   = allow & ~supp;
    assign wr     = load & src_v;

    always_comb begin
        src_d[0]  = in_data;
        src_wa[0] = in_rf_waddr;
        for (int i = 1; i < STAGES; i++) begin
            src_d[i]  = data_q[i-1];
            src_wa[i] = waddr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            we_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i]  <= '0;
                waddr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (kill[i])
                    valid_q[i] <= 1'b0;
                else if (allow[i])
                    valid_q[i] <= load[i] & src_v[i];
                if (wr[i]) begin
                    data_q[i]  <= src_d[i];
                    we_q[i]    <= src_we[i];
                    waddr_q[i] <= src_wa[i];
                end
            end
            if (in_valid & ~in_allow & ~&cnt_q)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign in_allow     = allow[0] & ~|flush_req;
    assign out_valid    = go[STAGES-1];
    assign out_data     = data_q[STAGES-1];
    assign out_rf_we    = valid_q[STAGES-1] & we_q[STAGES-1];
    assign out_rf_waddr = waddr_q[STAGES-1];
    assign stage_valid  = valid_q;
    assign stall_cnt    = cnt_q;
    assign occupancy    = occ;

    always_comb begin
        stage_data = '0;
        hit_vec1   = '0;
        hit_vec2   = '0;
        occ        = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_data[i*DATA_W +: DATA_W] = data_q[i];
            hit_vec1[i] = valid_q[i] & we_q[i] & (waddr_q[i] == query_raddr1)
                        & (query_raddr1 != '0);
            hit_vec2[i] = valid_q[i] & we_q[i] & (waddr_q[i] == query_raddr2)
                        & (query_raddr2 != '0);
            occ = occ + OCC_W'(valid_q[i]);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Bench for pipe_ctrl_chain: slot-level entry model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_pipe_ctrl_chain;

    localparam int S  = 5;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int CW = 32;
    localparam int OW = $clog2(S+1);

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_allow;
    logic [DW-1:0]  in_data;
    logic           in_rf_we;
    logic [AW-1:0]  in_rf_waddr;
    logic [S-1:0]   stage_ready_go;
    logic [S-1:0]   flush_req;
    logic           out_valid;
    logic           out_allow;
    logic [DW-1:0]  out_data;
    logic           out_rf_we;
    logic [AW-1:0]  out_rf_waddr;
    logic [S-1:0]   stage_valid;
    logic [S*DW-1:0] stage_data;
    logic [AW-1:0]  query_raddr1;
    logic [AW-1:0]  query_raddr2;
    logic [S-1:0]   hit_vec1;
    logic [S-1:0]   hit_vec2;
    logic [OW-1:0]  occupancy;
    logic [CW-1:0]  stall_cnt;

    pipe_ctrl_chain #(
        .STAGES(S), .DATA_W(DW), .RF_ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_allow(in_allow), .in_data(in_data),
        .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .stage_ready_go(stage_ready_go), .flush_req(flush_req),
        .out_valid(out_valid), .out_allow(out_allow), .out_data(out_data),
        .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .query_raddr1(query_raddr1), .query_raddr2(query_raddr2),
        .hit_vec1(hit_vec1), .hit_vec2(hit_vec2),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: one entry record per slot
    logic [S-1:0]  m_v;
    logic [S-1:0]  m_we;
    logic [DW-1:0] m_d  [S];
    logic [AW-1:0] m_wa [S];
    logic [CW-1:0] m_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int first_out = -1;
    logic [DW-1:0] got_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_v = '0; m_we = '0; m_cnt = '0;
        for (int i = 0; i < S; i++) begin
            m_d[i] = '0; m_wa[i] = '0;
        end
    endtask

    task automatic cycle();
        logic [S-1:0]  room, mv, eh1, eh2, n_v, n_we;
        logic [DW-1:0] n_d  [S];
        logic [AW-1:0] n_wa [S];
        logic [CW-1:0] n_cnt;
        logic          leave, e_ia;
        int            k, cnt;
        @(negedge clk);
        // an entry moves forward when the slot ahead of it is (or becomes) free
        leave = m_v[S-1] & stage_ready_go[S-1] & out_allow;
        room = '0; mv = '0;
        room[S-1] = !m_v[S-1] | leave;
        for (int i = S-1; i >= 1; i--) begin
            mv[i-1]   = m_v[i-1] & stage_ready_go[i-1] & room[i];
            room[i-1] = !m_v[i-1] | mv[i-1];
        end
        e_ia = room[0] && (flush_req == '0);
        cnt = 0;
        for (int i = 0; i < S; i++) begin
            eh1[i] = m_v[i] && m_we[i] && m_wa[i] == query_raddr1 && query_raddr1 != 0;
            eh2[i] = m_v[i] && m_we[i] && m_wa[i] == query_raddr2 && query_raddr2 != 0;
            if (m_v[i]) cnt++;
        end
        chk("stage_valid", 64'(stage_valid), 64'(m_v));
        for (int i = 0; i < S; i++)
            chk($sformatf("stage_data%0d", i), stage_data[i*DW +: DW], m_d[i]);
        chk("out_valid", 64'(out_valid), 64'(m_v[S-1] & stage_ready_go[S-1]));
        chk("out_data", out_data, m_d[S-1]);
        chk("out_rf_we", 64'(out_rf_we), 64'(m_v[S-1] & m_we[S-1]));
        chk("out_rf_waddr", 64'(out_rf_waddr), 64'(m_wa[S-1]));
        chk("in_allow", 64'(in_allow), 64'(e_ia));
        chk("occupancy", 64'(occupancy), 64'(cnt));
        chk("hit_vec1", 64'(hit_vec1), 64'(eh1));
        chk("hit_vec2", 64'(hit_vec2), 64'(eh2));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (out_valid && out_allow) begin
            got_q.push_back(out_data);
            if (first_out < 0) first_out = cyc;
        end
        k = -1;
        for (int j = 0; j < S; j++) if (flush_req[j]) k = j;
        n_v = m_v; n_we = m_we; n_d = m_d; n_wa = m_wa;
        if (leave) n_v[S-1] = 1'b0;
        for (int i = S-1; i >= 1; i--) begin
            if (mv[i-1]) begin
                n_v[i-1] = 1'b0;
                if (i > k) begin
                    n_v[i] = 1'b1; n_d[i] = m_d[i-1];
                    n_we[i] = m_we[i-1]; n_wa[i] = m_wa[i-1];
                end
            end
        end
        if (in_valid && e_ia) begin
            n_v[0] = 1'b1; n_d[0] = in_data;
            n_we[0] = in_rf_we; n_wa[0] = in_rf_waddr;
        end
        for (int i = 0; i < k; i++) n_v[i] = 1'b0;
        n_cnt = m_cnt;
        if (in_valid && !e_ia && m_cnt != '1) n_cnt = m_cnt + 1;
        @(posedge clk);
        if (reset) model_clear();
        else begin
            m_v = n_v; m_we = n_we; m_d = n_d; m_wa = n_wa; m_cnt = n_cnt;
        end
        cyc++;
        #1;
    endtask

    task automatic set_idle();
        in_valid = 0; in_data = '0; in_rf_we = 0; in_rf_waddr = '0;
        stage_ready_go = '1; flush_req = '0; out_allow = 1;
        query_raddr1 = '0; query_raddr2 = '0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1; cycle(); reset = 0;
    endtask

    task automatic fill(input logic [DW-1:0] base, input int n);
        out_allow = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1; in_data = base + DW'(i); in_rf_we = 0; in_rf_waddr = '0;
            cycle();
        end
        in_valid = 0;
    endtask

    initial begin
        int c0;
        int we_t [5] = '{1, 0, 1, 0, 1};
        int wa_t [5] = '{0, 7, 7, 7, 3};
        set_idle();
        reset = 1;
        @(posedge clk); #1;
        model_clear();
        do_reset();
        #1;
        chk("rst_in_allow", 64'(in_allow), 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_rf_we", 64'(out_rf_we), 64'd0);

        // streaming 1..10
        got_q.delete(); first_out = -1; c0 = cyc;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1; in_data = DW'(i); cycle();
        end
        in_valid = 0;
        repeat (8) cycle();
        chk("stream_count", 64'(got_q.size()), 64'd10);
        for (int i = 0; i < got_q.size(); i++)
            chk("stream_order", got_q[i], 64'(i+1));
        chk("stream_latency", 64'(first_out - c0), 64'd5);
        chk("stream_stall", 64'(stall_cnt), 64'd0);

        // backpressure
        do_reset();
        fill(101, 5);
        in_valid = 1; in_data = 64'd999; out_allow = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_occupancy", 64'(occupancy), 64'd5);
            chk("bp_in_allow", 64'(in_allow), 64'd0);
            cycle();
        end
        chk("bp_stall", 64'(stall_cnt), 64'd3);
        got_q.delete();
        in_valid = 0; out_allow = 1;
        repeat (8) cycle();
        chk("bp_count", 64'(got_q.size()), 64'd5);
        for (int i = 0; i < got_q.size(); i++)
            chk("bp_order", got_q[i], 64'(101+i));

        // bubble behind a stalled slot 2
        do_reset();
        fill(301, 5);
        stage_ready_go = 5'b11011; out_allow = 1; in_valid = 1; in_data = 64'd998;
        #1;
        chk("bub_in_allow", 64'(in_allow), 64'd0);
        cycle();
        chk("bub_valid1", 64'(stage_valid), 64'b10111);
        cycle();
        chk("bub_valid2", 64'(stage_valid), 64'b00111);
        in_valid = 0; stage_ready_go = '1;
        repeat (6) cycle();

        // flush from slot 3, alone and with a lower bit also set
        for (int t = 0; t < 2; t++) begin
            do_reset();
            fill(DW'(401 + 100*t), 5);
            flush_req = (t == 0) ? 5'b01000 : 5'b01010;
            out_allow = 1; in_valid = 1; in_data = 64'd997;
            #1;
            chk("fl_in_allow", 64'(in_allow), 64'd0);
            cycle();
            flush_req = '0; in_valid = 0; out_allow = 0;
            #1;
            chk("fl_valid", 64'(stage_valid), 64'b10000);
            chk("fl_slot4", stage_data[4*DW +: DW], 64'(402 + 100*t));
            out_allow = 1;
            repeat (3) cycle();
        end

        // scoreboard query
        do_reset();
        out_allow = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = DW'(601+i);
            in_rf_we = we_t[i][0]; in_rf_waddr = AW'(wa_t[i]);
            cycle();
        end
        in_valid = 0; in_rf_we = 0;
        query_raddr1 = 5'd7; query_raddr2 = 5'd0;
        #1;
        chk("sb_hit1", 64'(hit_vec1), 64'b00100);
        chk("sb_hit2", 64'(hit_vec2), 64'b00000);
        cycle();
        query_raddr2 = 5'd3;
        #1;
        chk("sb_hit2_r3", 64'(hit_vec2), 64'b00001);
        cycle();

        // reset mid-stream
        do_reset();
        fill(701, 4);
        flush_req = 5'b00001; in_valid = 1;
        repeat (9) cycle();
        chk("mr_stall", 64'(stall_cnt), 64'd9);
        chk("mr_occupancy", 64'(occupancy), 64'd4);
        flush_req = '0; in_valid = 0; reset = 1;
        cycle();
        reset = 0;
        #1;
        chk("mr_valid", 64'(stage_valid), 64'd0);
        chk("mr_occ0", 64'(occupancy), 64'd0);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_stall0", 64'(stall_cnt), 64'd0);
        chk("mr_in_allow", 64'(in_allow), 64'd1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            in_data = {$urandom(), $urandom()};
            in_rf_we = $urandom_range(0, 1) == 1;
            in_rf_waddr = AW'($urandom_range(0, 7));
            stage_ready_go = S'(~($urandom() & $urandom()));
            flush_req = ($urandom_range(0, 15) == 0) ? S'($urandom()) : '0;
            out_allow = $urandom_range(0, 3) != 0;
            query_raddr1 = AW'($urandom_range(0, 7));
            query_raddr2 = AW'($urandom_range(0, 7));
            cycle();
        end
        reset = 0;
        set_idle();
        repeat (8) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
